// File: rtl/uart_fifo_bridge_if.sv
// Core-side byte-FIFO port of the UART bridge: RX drain, TX push, busy and sticky error flags.
// The core drives the master side; the bridge implements the slave side.
interface uart_fifo_bridge_if;
   logic       uart_empty;
   logic [7:0] uart_in;
   logic       uart_rdreq;
   logic [7:0] uart_out;
   logic       uart_wrreq;
   logic       tx_busy;
   logic       rx_overflow;
   logic       tx_overflow;
   logic       frame_error;
   logic       err_clr;

   modport master (
      input  uart_empty, uart_in, tx_busy, rx_overflow, tx_overflow, frame_error,
      output uart_rdreq, uart_out, uart_wrreq, err_clr
   );

   modport slave (
      output uart_empty, uart_in, tx_busy, rx_overflow, tx_overflow, frame_error,
      input  uart_rdreq, uart_out, uart_wrreq, err_clr
   );
endinterface

// File: rtl/uart_fifo_bridge.sv
// 8N1 UART bridge: RXD is deserialized into an RX byte FIFO drained by the core, and bytes
// the core pushes into a TX FIFO are serialized onto TXD, LSB first.

module uart_fifo_bridge_fifo #(
   parameter int AW = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] head,
   output logic       empty,
   output logic       dropped
);
   localparam int          DEPTH = 1 << AW;
   localparam logic [AW:0] FULL  = {1'b1, {AW{1'b0}}};

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   // A pop on a full FIFO frees the slot the simultaneous push needs.
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && ((count != FULL) || do_pop);
   assign dropped = push && !do_push;
   assign head    = mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

module uart_fifo_bridge #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_AW      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rxd,
   output logic              txd,
   uart_fifo_bridge_if.slave core
);
   localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   logic       rx_meta, rxs;
   logic       rx_push, rx_ferr, rx_drop, rx_empty;
   logic [7:0] rx_head;
   logic       tx_pop, tx_drop, tx_empty;
   logic [7:0] tx_head;

   uart_state_e   rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_sh, rx_sh_n;
   logic          rx_wait, rx_wait_n;

   uart_state_e   tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_bit, tx_bit_n;
   logic [7:0]    tx_sh, tx_sh_n;
   logic          txd_n;

   uart_fifo_bridge_fifo #(.AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_sh), .pop(core.uart_rdreq),
      .head(rx_head), .empty(rx_empty), .dropped(rx_drop)
   );

   uart_fifo_bridge_fifo #(.AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push(core.uart_wrreq), .din(core.uart_out), .pop(tx_pop),
      .head(tx_head), .empty(tx_empty), .dropped(tx_drop)
   );

   assign core.uart_empty = rx_empty;
   assign core.uart_in    = rx_empty ? 8'h00 : rx_head;
   assign core.tx_busy    = !tx_empty || (tx_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
      end
   end

   // rx_cnt counts clocks since the previous sample point; a frame that ends on a low stop bit
   // parks in STOP (rx_wait) until the line returns high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         rx_wait  <= 1'b0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
         rx_wait  <= rx_wait_n;
      end
   end

   // NOTE: every always_comb output is given a default first, so no path can infer a latch.
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      rx_wait_n  = rx_wait;
      rx_push    = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state)
         S_IDLE: if (!rxs) begin
            rx_state_n = S_START;
            rx_cnt_n   = CW'(1);
         end
         S_START: if (rx_cnt == HALF) begin
            rx_cnt_n   = CW'(1);
            rx_bit_n   = '0;
            rx_state_n = rxs ? S_IDLE : S_DATA;
         end else rx_cnt_n = rx_cnt + 1'b1;
         S_DATA: if (rx_cnt == FULL_BIT) begin
            rx_cnt_n = CW'(1);
            rx_sh_n  = {rxs, rx_sh[7:1]};
            rx_bit_n = rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state_n = S_STOP;
         end else rx_cnt_n = rx_cnt + 1'b1;
         S_STOP: if (rx_wait) begin
            if (rxs) begin
               rx_wait_n  = 1'b0;
               rx_state_n = S_IDLE;
            end
         end else if (rx_cnt == FULL_BIT) begin
            if (rxs) begin
               rx_push    = 1'b1;
               rx_state_n = S_IDLE;
            end else begin
               rx_ferr   = 1'b1;
               rx_wait_n = 1'b1;
            end
         end else rx_cnt_n = rx_cnt + 1'b1;
         default: rx_state_n = S_IDLE;
      endcase
   end

   // txd is registered from the current state, so the line lags the FSM by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         txd      <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
         txd      <= txd_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_sh_n    = tx_sh;
      tx_pop     = 1'b0;
      case (tx_state)
         S_IDLE: if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_n    = tx_head;
            tx_cnt_n   = '0;
            tx_state_n = S_START;
         end
         S_START: if (tx_cnt == LAST) begin
            tx_cnt_n   = '0;
            tx_bit_n   = '0;
            tx_state_n = S_DATA;
         end else tx_cnt_n = tx_cnt + 1'b1;
         S_DATA: if (tx_cnt == LAST) begin
            tx_cnt_n = '0;
            tx_sh_n  = {1'b0, tx_sh[7:1]};
            tx_bit_n = tx_bit + 1'b1;
            if (tx_bit == 3'd7) tx_state_n = S_STOP;
         end else tx_cnt_n = tx_cnt + 1'b1;
         S_STOP: if (tx_cnt == LAST) tx_state_n = S_IDLE;
                 else tx_cnt_n = tx_cnt + 1'b1;
         default: tx_state_n = S_IDLE;
      endcase
      case (tx_state)
         S_START: txd_n = 1'b0;
         S_DATA:  txd_n = tx_sh[0];
         default: txd_n = 1'b1;
      endcase
   end

   // Sticky flags: a set in the same cycle as err_clr wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core.rx_overflow <= 1'b0;
         core.tx_overflow <= 1'b0;
         core.frame_error <= 1'b0;
      end else begin
         if (rx_drop)           core.rx_overflow <= 1'b1;
         else if (core.err_clr) core.rx_overflow <= 1'b0;
         if (tx_drop)           core.tx_overflow <= 1'b1;
         else if (core.err_clr) core.tx_overflow <= 1'b0;
         if (rx_ferr)           core.frame_error <= 1'b1;
         else if (core.err_clr) core.frame_error <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: directed steps with random payloads, a TXD frame
// decoder and byte queues as the reference for what must come out of each side.
module tb_uart_fifo_bridge;
   localparam int C     = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_n;
   logic rxd_drv;
   logic loop_en;
   logic txd;
   logic rxd;

   always #5 clk = ~clk;
   assign rxd = loop_en ? txd : rxd_drv;

   uart_fifo_bridge_if bus ();

   uart_fifo_bridge #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .txd(txd), .core(bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   logic [8:0]  mon_frames[$];
   int unsigned mon_starts[$];
   logic [7:0]  rx_exp[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Decodes every frame seen on TXD at mid-bit points: {stop, data} plus the start clock.
   initial begin
      logic [8:0]  f;
      int unsigned t0;
      forever begin
         @(posedge clk); #1;
         if (rst_n === 1'b1 && txd === 1'b0) begin
            t0 = cyc;
            repeat (C/2) @(posedge clk); #1;
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(posedge clk); #1;
               f[i] = txd;
            end
            repeat (C) @(posedge clk); #1;
            f[8] = txd;
            mon_frames.push_back(f);
            mon_starts.push_back(t0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rxd_drv = 1'b0;
      tick(C);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = b[i];
         tick(C);
      end
      rxd_drv = stop_bit;
      tick(C);
      rxd_drv = 1'b1;
      tick(2);
   endtask

   task automatic drain_rx(input string tag);
      while (rx_exp.size() > 0) begin
         logic [7:0] e;
         e = rx_exp.pop_front();
         check({tag, " not empty"}, bus.uart_empty, 1'b0);
         check({tag, " byte"}, bus.uart_in, e);
         bus.uart_rdreq = 1'b1;
         tick(1);
         bus.uart_rdreq = 1'b0;
      end
      check({tag, " drained"}, bus.uart_empty, 1'b1);
   endtask

   task automatic wait_tx_idle(input int budget);
      int k = 0;
      while (bus.tx_busy !== 1'b0 && k < budget) begin
         tick(1);
         k++;
      end
      check("tx idle within budget", bus.tx_busy, 1'b0);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] bytes[$];

      rst_n          = 1'b0;
      rxd_drv        = 1'b1;
      loop_en        = 1'b0;
      bus.uart_rdreq = 1'b0;
      bus.uart_wrreq = 1'b0;
      bus.uart_out   = 8'h00;
      bus.err_clr    = 1'b0;
      tick(3);

      check("reset txd", txd, 1'b1);
      check("reset uart_empty", bus.uart_empty, 1'b1);
      check("reset uart_in", bus.uart_in, 8'h00);
      check("reset tx_busy", bus.tx_busy, 1'b0);
      check("reset rx_overflow", bus.rx_overflow, 1'b0);
      check("reset tx_overflow", bus.tx_overflow, 1'b0);
      check("reset frame_error", bus.frame_error, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      tick(3);

      // Single TX byte with exact edge timing.
      b = 8'hA5;
      bus.uart_out   = b;
      bus.uart_wrreq = 1'b1;
      tick(1);
      bus.uart_wrreq = 1'b0;
      check("a5 busy after write edge", bus.tx_busy, 1'b1);
      check("a5 txd high at N", txd, 1'b1);
      tick(1);
      check("a5 txd high at N+1", txd, 1'b1);
      tick(1);
      check("a5 txd low at N+2", txd, 1'b0);
      tick(C/2);
      check("a5 start mid", txd, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick(C);
         check("a5 data bit", txd, b[i]);
      end
      tick(C);
      check("a5 stop bit", txd, 1'b1);
      tick(C - 2 - C/2);
      check("a5 busy at N+10C", bus.tx_busy, 1'b1);
      tick(1);
      check("a5 idle at N+10C+1", bus.tx_busy, 1'b0);

      // Loopback: back-to-back frames come back in order, 10*C+1 clocks apart.
      tick(2 * C);
      mon_frames.delete();
      mon_starts.delete();
      loop_en = 1'b1;
      bytes   = '{8'h00, 8'hFF, 8'h3C};
      for (int i = 0; i < 5; i++) bytes.push_back(8'($urandom));
      foreach (bytes[i]) begin
         bus.uart_out   = bytes[i];
         bus.uart_wrreq = 1'b1;
         tick(1);
      end
      bus.uart_wrreq = 1'b0;
      wait_tx_idle(20 * C * bytes.size());
      tick(4 * C);
      check("loop frame count", mon_frames.size(), bytes.size());
      for (int i = 0; i < mon_frames.size() && i < bytes.size(); i++)
         check("loop tx frame", mon_frames[i], {1'b1, bytes[i]});
      for (int i = 1; i < mon_starts.size(); i++)
         check("loop frame spacing", mon_starts[i] - mon_starts[i-1], 10 * C + 1);
      rx_exp = bytes;
      drain_rx("loop rx");
      check("loop rx_overflow", bus.rx_overflow, 1'b0);
      check("loop tx_overflow", bus.tx_overflow, 1'b0);
      check("loop frame_error", bus.frame_error, 1'b0);
      loop_en = 1'b0;

      // RX overflow: 17 frames into a 16-deep FIFO with no reads.
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         if (i < DEPTH) rx_exp.push_back(b);
         send_frame(b, 1'b1);
         if (i == DEPTH - 1) check("rx_overflow clear when just full", bus.rx_overflow, 1'b0);
      end
      check("rx_overflow set", bus.rx_overflow, 1'b1);
      check("rx full not empty", bus.uart_empty, 1'b0);
      drain_rx("rx ovf");
      check("rx drained uart_in", bus.uart_in, 8'h00);
      bus.uart_rdreq = 1'b1;
      tick(2);
      bus.uart_rdreq = 1'b0;
      tick(1);
      check("pop on empty keeps empty", bus.uart_empty, 1'b1);
      check("pop on empty uart_in", bus.uart_in, 8'h00);

      // Frame error, err_clr, then a short glitch.
      send_frame(8'h55, 1'b0);
      tick(C);
      check("frame_error set", bus.frame_error, 1'b1);
      check("bad frame not stored", bus.uart_empty, 1'b1);
      bus.err_clr = 1'b1;
      tick(1);
      bus.err_clr = 1'b0;
      check("err_clr frame_error", bus.frame_error, 1'b0);
      check("err_clr rx_overflow", bus.rx_overflow, 1'b0);
      rxd_drv = 1'b0;
      tick(2);
      rxd_drv = 1'b1;
      tick(3 * C);
      check("glitch no byte", bus.uart_empty, 1'b1);
      check("glitch no flag", bus.frame_error, 1'b0);
      b = 8'($urandom);
      send_frame(b, 1'b1);
      check("rx after glitch", bus.uart_in, b);
      bus.uart_rdreq = 1'b1;
      tick(1);
      bus.uart_rdreq = 1'b0;

      // TX overflow: 18 consecutive writes, 17 accepted.
      mon_frames.delete();
      bytes.delete();
      for (int i = 0; i < DEPTH + 2; i++) begin
         b = 8'($urandom);
         bytes.push_back(b);
         bus.uart_out   = b;
         bus.uart_wrreq = 1'b1;
         tick(1);
         if (i == DEPTH) check("tx_overflow clear after 17th write", bus.tx_overflow, 1'b0);
      end
      bus.uart_wrreq = 1'b0;
      check("tx_overflow set", bus.tx_overflow, 1'b1);
      wait_tx_idle(20 * C * (DEPTH + 2));
      tick(C);
      check("tx ovf frame count", mon_frames.size(), DEPTH + 1);
      for (int i = 0; i < mon_frames.size() && i < DEPTH + 1; i++)
         check("tx ovf frame", mon_frames[i], {1'b1, bytes[i]});

      // Reset in the middle of a TX data bit with both FIFOs holding data.
      b = 8'($urandom);
      send_frame(b, 1'b1);
      check("pre-reset rx byte present", bus.uart_empty, 1'b0);
      b = 8'($urandom) & 8'hFE;
      bus.uart_out   = b;
      bus.uart_wrreq = 1'b1;
      tick(1);
      bus.uart_out = 8'($urandom);
      tick(1);
      bus.uart_wrreq = 1'b0;
      tick(C + 3);
      check("pre-reset data bit low", txd, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async reset txd", txd, 1'b1);
      check("async reset tx_busy", bus.tx_busy, 1'b0);
      check("async reset uart_empty", bus.uart_empty, 1'b1);
      check("async reset uart_in", bus.uart_in, 8'h00);
      check("async reset tx_overflow", bus.tx_overflow, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      tick(12 * C);
      check("post-reset stays idle", bus.tx_busy, 1'b0);
      mon_frames.delete();
      b = 8'($urandom);
      bus.uart_out   = b;
      bus.uart_wrreq = 1'b1;
      tick(1);
      bus.uart_wrreq = 1'b0;
      check("fresh txd high at N", txd, 1'b1);
      tick(1);
      check("fresh txd high at N+1", txd, 1'b1);
      tick(1);
      check("fresh txd low at N+2", txd, 1'b0);
      wait_tx_idle(20 * C);
      tick(C);
      check("fresh frame count", mon_frames.size(), 1);
      for (int i = 0; i < mon_frames.size(); i++)
         check("fresh frame", mon_frames[i], {1'b1, b});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/uart_fifo_bridge.md
# uart_fifo_bridge

Serial-side counterpart of the core's byte-FIFO UART port. Deserializes the RXD line into a receive FIFO, which the core drains through `uart_empty`/`uart_in`/`uart_rdreq`. Bytes the core pushes through `uart_out`/`uart_wrreq` go into a transmit FIFO and are serialized onto TXD. Frame format is 8N1, LSB first. The block sits at the top level between the core's UART pins and the board's serial lines.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clocks per bit period; must be ≥ 4.
- `FIFO_AW`, 4: FIFO address width; each FIFO holds 2^FIFO_AW bytes.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rxd` in 1: serial input; asynchronous; idles high.
- `txd` out 1: serial output; idles high.
- `uart_empty` out 1: RX FIFO empty.
- `uart_in` out 8: RX FIFO head byte (show-ahead); 8'h00 when empty.
- `uart_rdreq` in 1: pop RX FIFO this cycle.
- `uart_out` in 8: byte to transmit.
- `uart_wrreq` in 1: push `uart_out` into TX FIFO this cycle.
- `tx_busy` out 1: TX FIFO non-empty or a frame is in progress.
- `rx_overflow` out 1: sticky; a received byte was dropped because the RX FIFO was full.
- `tx_overflow` out 1: sticky; a write was dropped because the TX FIFO was full.
- `frame_error` out 1: sticky; a stop bit was sampled low.
- `err_clr` in 1: synchronous clear of all three sticky flags. A set in the same cycle wins.

## Operation
- **Reset values:** `txd`=1, `uart_empty`=1, `uart_in`=0, `tx_busy`=0, all flags 0. Both FIFOs are emptied and both FSMs return to IDLE. Asserting reset mid-frame aborts the frame, and TXD goes high immediately.
- **FIFOs:** circular buffers with FIFO_AW-bit pointers plus a FIFO_AW+1-bit count.
  - Push and pop in the same cycle: both occur and the count is unchanged. This holds when full (pop frees the slot) but not when empty (the pop is ignored and the push proceeds).
  - Pop when empty: ignored.
  - Push when full without a simultaneous pop: byte dropped, matching overflow flag set.
- **RX synchronizer:** two-flop synchronizer on `rxd`. The RX FSM sees only the synchronized value `rxs`.
- **RX FSM:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: `rxs`=0 starts a bit counter and moves to START.
  - START: at count CLKS_PER_BIT/2 (integer division), `rxs` is resampled. If 1, the start was a glitch: return to IDLE, no flag. If 0, enter DATA.
  - DATA: 8 samples, each CLKS_PER_BIT clocks after the previous one, shifted in LSB first.
  - STOP: sampled CLKS_PER_BIT later. If 1, push the byte into the RX FIFO. If 0, discard the byte, set `frame_error`, and stay in STOP until `rxs`=1 before entering IDLE.
- **TX FSM:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: if the TX FIFO is non-empty, pop the head into the shift register; go to START on the next edge.
  - Each of START (`txd`=0), the 8 DATA bits (LSB first), and STOP (`txd`=1) is held exactly CLKS_PER_BIT clocks.
  - After STOP, one IDLE cycle follows before the next pop. Back-to-back frames are therefore 10·CLKS_PER_BIT+1 clocks apart.
- **tx_busy:** `tx_busy` = (TX count≠0) | (TX state≠IDLE).

## Timing
- **uart_in / uart_empty:** combinational from RX FIFO state. `uart_in` shows the head combinationally. `uart_empty` and a newly pushed byte become visible the cycle after the push edge.
- **uart_rdreq:** `uart_in` changes to the next entry the cycle after the `uart_rdreq` edge.
- **TX latency:** with `uart_wrreq` high in cycle N into an empty, idle TX path, the byte is written at edge N. IDLE pops at edge N+1, and `txd` falls at edge N+2.
- **RX latency:** a byte appears (`uart_empty`=0) 1 clock after the stop-bit sample edge.
- **RX sample point:** stop-bit sample lands 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT clocks after the start-bit falling edge on `rxd`, including synchronizer delay.
- **Flag timing:** sticky flags rise on the edge where the drop or error occurs and stay high until `err_clr` or reset.

## Test plan
- **Single TX byte** (CLKS_PER_BIT=8): write 8'hA5 → `txd` low at edge N+2, then bits 1,0,1,0,0,1,0,1 (8 clocks each), then high. `tx_busy` falls after the 80th bit clock plus the return to IDLE.
- **Loopback:** with `txd` tied to `rxd`, write 8'h00, 8'hFF, 8'h3C back-to-back → RX FIFO yields 00, FF, 3C in order; no flags set; frame spacing 81 clocks.
- **RX overflow:** drive 17 frames with FIFO_AW=4 and no reads → `uart_empty`=0, 16 bytes retained, `rx_overflow`=1, 17th byte lost. Pop all 16 → `uart_empty`=1, and further `uart_rdreq` has no effect.
- **Frame error and glitch:** send 8'h55 with stop bit 0 → `frame_error`=1, FIFO unchanged. Send a 2-clock low glitch → no byte, no flag. Assert `err_clr` → flag cleared.
- **TX overflow:** 18 writes in consecutive cycles → 17 accepted (one popped at edge N+1), `tx_overflow`=1, 17 frames emitted.
- **Reset mid-frame:** assert `rst_n`=0 during TX DATA → `txd`=1 asynchronously, FIFOs empty. After release, the first write starts a fresh frame at N+2.
